midi_tx: RTL and testbench
==========================

// Module: midi_tx
// PURPOSE
//  Encodes 24-bit MIDI messages {status[23:16], data1[15:8], data2[7:0]} into a MIDI serial
//  stream (UART 8N1, LSB first, idle high, 31250 baud). Transmit end of the same MIDI
//  message format our note-decode path consumes (note number in [15:8]). Drives the
//  physical MIDI OUT pin.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency
//  BAUD            31250       serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, >=4)
//  RUNNING_STATUS  0           1 = omit repeated channel-voice status byte
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst        in   1   synchronous, active-high reset
//  msg_i      in   24  message: [23:16] status, [15:8] data1, [7:0] data2
//  msg_valid  in   1   msg_i valid
//  msg_ready  out  1   block can accept; transfer on msg_valid && msg_ready
//  tx         out  1   serial MIDI out, idle 1
//  busy       out  1   1 while any frame is in flight
// BEHAVIOUR
//  Reset: tx=1, busy=0, msg_ready=1, FSM=IDLE, last_status=0x00 (none).
//  msg_ready = (state==IDLE); no skid buffer, one message in flight.
//  Handshake cycle: latch msg_i, compute byte count:
//   0x80-0xBF, 0xE0-0xEF: 3 bytes; 0xC0-0xDF: 2 bytes; 0xF0-0xFF: 1 byte (status only);
//   status[7]==0: message accepted and dropped, no tx activity, stays IDLE.
//  Running status (param=1): channel-voice status (0x80-0xEF) equal to last_status -> status
//   byte skipped. last_status updated on every channel-voice send; cleared by 0xF0-0xF7;
//   0xF8-0xFF (realtime) leave it unchanged. Param=0: last_status unused.
//  FSM: IDLE -> START (tx=0) -> DATA (8 bits, LSB first) -> STOP (tx=1) -> START of next
//   byte with no idle gap, or IDLE after last byte. Each state/bit held CLKS_PER_BIT cycles
//   by a bit-timer counting 0..CLKS_PER_BIT-1; 3-bit bit index; 2-bit byte index.
//  Latency: tx falls on the first clock edge after the handshake cycle. N-byte message
//   occupies exactly N*10*CLKS_PER_BIT cycles of tx; msg_ready rises the cycle after the
//   final stop bit completes. busy==!msg_ready.
//  tx is a registered output (glitch-free).
//  Reset mid-operation: frame aborted, all outputs to reset values on the next edge;
//   partial byte not resumed.
//  msg_valid while busy: ignored (upstream holds it until msg_ready).
// STRUCTURE
//  midi_pkg: typedef midi_msg_t (packed struct status/data1/data2), status range constants
//   (NOTE_OFF 0x80, PROG_CHG 0xC0, CHAN_PRES 0xD0, SYSEX 0xF0, RT_BASE 0xF8), function
//   midi_len(status)->0..3.
//  Sub-module uart_tx_byte: one 8N1 byte serializer (start/ready/done, CLKS_PER_BIT param);
//   midi_tx holds message FSM, byte sequencing and running-status logic.
// TESTING  (CLK_HZ=312_500, BAUD=31250 -> 10 clk/bit)
//  1 Note-on 0x90_45_64 -> tx frames 0x90,0x45,0x64 back-to-back, 300 cycles; msg_ready=1
//    at cycle 301 after handshake.
//  2 Program change 0xC3_05_7F -> frames 0xC3,0x05 only, 200 cycles; 0x7F never sent.
//  3 RUNNING_STATUS=1: 0x90_3C_40 then 0x90_3E_40 then 0x80_3C_00 -> 3 bytes, 2 bytes
//    (0x3E,0x40), 3 bytes.
//  4 RUNNING_STATUS=1: 0x90_3C_40, 0xF8_xx_xx, 0x90_3E_40 -> 0xF8 single byte, third msg
//    2 bytes; repeat with 0xF0 in middle -> third msg 3 bytes.
//  5 Invalid 0x45_12_34 -> accepted, tx stays 1, msg_ready=1 next cycle.
//  6 rst pulsed during data bit 3 of byte 2 -> tx=1, busy=0, msg_ready=1 next edge; next
//    0x90_3C_40 with RUNNING_STATUS=1 sends full 3 bytes.

Source files
------------

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - MIDI message layout, status ranges and per-status byte count
package midi_pkg;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
    } midi_msg_t;

    localparam logic [7:0] NOTE_OFF  = 8'h80;
    localparam logic [7:0] PROG_CHG  = 8'hC0;
    localparam logic [7:0] CHAN_PRES = 8'hD0;
    localparam logic [7:0] SYSEX     = 8'hF0;
    localparam logic [7:0] RT_BASE   = 8'hF8;

    // Bytes on the wire for a status; 0 means not a status byte (message dropped).
    function automatic logic [1:0] midi_len(input logic [7:0] status);
        if (status < NOTE_OFF) begin
            return 2'd0;
        end else if (status >= SYSEX) begin
            return 2'd1;
        end else if (status >= PROG_CHG && status <= (CHAN_PRES | 8'h0F)) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    function automatic logic is_chan_voice(input logic [7:0] status);
        return (status >= NOTE_OFF) && (status < SYSEX);
    endfunction

    function automatic logic is_sys_common(input logic [7:0] status);
        return (status >= SYSEX) && (status < RT_BASE);
    endfunction

    function automatic logic [7:0] msg_byte(input midi_msg_t msg, input logic [1:0] idx);
        case (idx)
            2'd0:    return msg.status;
            2'd1:    return msg.data1;
            default: return msg.data2;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer, LSB first, registered idle-high line
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_tick;

    assign w_tick  = (r_timer == LAST_TICK);
    // Ready during the last stop-bit cycle lets the next start bit follow with no idle gap.
    assign o_done  = (r_state == S_STOP) && w_tick;
    assign o_ready = (r_state == S_IDLE) || o_done;
    assign o_tx    = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else if (i_start && o_ready) begin
            r_state   <= S_START;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= i_data;
            r_tx      <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (!w_tick) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                    S_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI message transmitter: byte sequencing and running status over 8N1
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 31250,
    parameter bit RUNNING_STATUS = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] msg_i,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        tx,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0] r_state;
    midi_msg_t  r_msg;
    logic [1:0] r_byte_idx;
    logic [1:0] r_byte_cnt;
    logic [7:0] r_last_status;

    midi_msg_t  w_msg;
    logic       w_accept;
    logic [1:0] w_len;
    logic       w_skip;
    logic [1:0] w_first_idx;
    logic       w_more;
    logic       w_start;
    logic [7:0] w_byte;
    logic       w_uart_ready;
    logic       w_uart_done;
    logic       w_uart_tx;

    assign w_msg       = midi_msg_t'(msg_i);
    assign w_accept    = msg_valid && (r_state == S_IDLE);
    assign w_len       = midi_len(w_msg.status);
    assign w_skip      = RUNNING_STATUS && is_chan_voice(w_msg.status)
                         && (w_msg.status == r_last_status);
    assign w_first_idx = {1'b0, w_skip};
    assign w_more      = (r_byte_idx + 2'd1) < r_byte_cnt;

    // First byte is taken straight from msg_i so tx falls on the handshake edge.
    always_comb begin
        w_start = 1'b0;
        w_byte  = 8'h00;
        if (w_accept && (w_len != 2'd0)) begin
            w_start = 1'b1;
            w_byte  = msg_byte(w_msg, w_first_idx);
        end else if ((r_state == S_SEND) && w_uart_done && w_more) begin
            w_start = 1'b1;
            w_byte  = msg_byte(r_msg, r_byte_idx + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_msg         <= '0;
            r_byte_idx    <= '0;
            r_byte_cnt    <= '0;
            r_last_status <= 8'h00;
        end else if (w_accept) begin
            if (w_len != 2'd0) begin
                r_state    <= S_SEND;
                r_msg      <= w_msg;
                r_byte_idx <= w_first_idx;
                r_byte_cnt <= w_len;
            end
            // Realtime bytes and non-status values leave running status untouched.
            if (is_chan_voice(w_msg.status)) begin
                r_last_status <= w_msg.status;
            end else if (is_sys_common(w_msg.status)) begin
                r_last_status <= 8'h00;
            end
        end else if ((r_state == S_SEND) && w_uart_done) begin
            if (w_more) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_byte),
        .o_ready (w_uart_ready),
        .o_done  (w_uart_done),
        .o_tx    (w_uart_tx)
    );

    logic w_unused;
    assign w_unused  = w_uart_ready;

    assign msg_ready = (r_state == S_IDLE);
    assign busy      = !msg_ready;
    assign tx        = w_uart_tx;

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx with and without running status
module tb_midi_tx;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] msg_i;
    logic        msg_valid;
    wire  [1:0]  tx_w;
    wire  [1:0]  rdy_w;
    wire  [1:0]  busy_w;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    midi_tx #(.CLK_HZ(312_500), .BAUD(31250), .RUNNING_STATUS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .msg_i(msg_i), .msg_valid(msg_valid),
        .msg_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    midi_tx #(.CLK_HZ(312_500), .BAUD(31250), .RUNNING_STATUS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .msg_i(msg_i), .msg_valid(msg_valid),
        .msg_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected line level per cycle, one queue entry per clock.
    bit         q0[$];
    bit         q1[$];
    logic [7:0] m_last [2];

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push_byte(int d, logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB; c++)
                if (d == 0) q0.push_back(fr[i]); else q1.push_back(fr[i]);
    endfunction

    function automatic void model_accept(int d, logic [23:0] m);
        logic [7:0] st;
        int n;
        int first;
        st = m[23:16];
        if (st < 8'h80)      n = 0;
        else if (st >= 8'hF0) n = 1;
        else if (st >= 8'hC0 && st < 8'hE0) n = 2;
        else                  n = 3;
        first = (d == 1 && st >= 8'h80 && st < 8'hF0 && st == m_last[d]) ? 1 : 0;
        for (int i = first; i < n; i++)
            push_byte(d, (i == 0) ? st : (i == 1) ? m[15:8] : m[7:0]);
        if (st >= 8'h80 && st < 8'hF0)      m_last[d] = st;
        else if (st >= 8'hF0 && st < 8'hF8) m_last[d] = 8'h00;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                bit idle;
                bit etx;
                idle = (qsize(d) == 0);
                etx  = idle ? 1'b1 : ((d == 0) ? q0[0] : q1[0]);
                chk($sformatf("tx%0d", d), tx_w[d], etx);
                chk($sformatf("ready%0d", d), rdy_w[d], idle);
                chk($sformatf("busy%0d", d), busy_w[d], !idle);
                if (!idle) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                if (rst) begin
                    if (d == 0) q0.delete(); else q1.delete();
                    m_last[d] = 8'h00;
                end else if (idle && msg_valid) begin
                    model_accept(d, msg_i);
                end
            end
        end
    end

    // Line decoder: start detect, sample mid-bit, check stop bit.
    bit         dec_act [2];
    int         dec_cnt [2];
    logic [7:0] dec_sh  [2];
    logic [7:0] rx0[$];
    logic [7:0] rx1[$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || !check_en) begin
                dec_act[d] = 1'b0;
            end else if (!dec_act[d]) begin
                if (tx_w[d] == 1'b0) begin
                    dec_act[d] = 1'b1;
                    dec_cnt[d] = 0;
                end
            end else begin
                dec_cnt[d]++;
                if (dec_cnt[d] >= 15 && dec_cnt[d] <= 85 && (dec_cnt[d] - 15) % CPB == 0) begin
                    dec_sh[d] = {tx_w[d], dec_sh[d][7:1]};
                end else if (dec_cnt[d] == 95) begin
                    chk($sformatf("stop%0d", d), tx_w[d], 1'b1);
                    if (d == 0) rx0.push_back(dec_sh[d]); else rx1.push_back(dec_sh[d]);
                    dec_act[d] = 1'b0;
                end
            end
        end
    end

    localparam logic [7:0] EXP0 [0:31] = '{
        8'h90, 8'h45, 8'h64, 8'hC3, 8'h05, 8'h90, 8'h3C, 8'h40,
        8'h90, 8'h3E, 8'h40, 8'h80, 8'h3C, 8'h00, 8'h90, 8'h3C,
        8'h40, 8'hF8, 8'h90, 8'h3E, 8'h40, 8'h90, 8'h3C, 8'h40,
        8'hF0, 8'h90, 8'h3E, 8'h40, 8'h90, 8'h90, 8'h3C, 8'h40};
    localparam logic [7:0] EXP1 [0:28] = '{
        8'h90, 8'h45, 8'h64, 8'hC3, 8'h05, 8'h90, 8'h3C, 8'h40,
        8'h3E, 8'h40, 8'h80, 8'h3C, 8'h00, 8'h90, 8'h3C, 8'h40,
        8'hF8, 8'h3E, 8'h40, 8'h3C, 8'h40, 8'hF0, 8'h90, 8'h3E,
        8'h40, 8'h3C, 8'h90, 8'h3C, 8'h40};

    task automatic wait_ready();
        int w;
        w = 0;
        while (!(rdy_w[0] && rdy_w[1]) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("wait_ready", rdy_w, 2'b11);
    endtask

    task automatic handshake(input logic [23:0] m);
        wait_ready();
        msg_i     = m;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        msg_i     = 24'($urandom);
    endtask

    // exp0/exp1: cycle after the handshake at which msg_ready is back to 1.
    task automatic send(input logic [23:0] m, input int exp0, input int exp1);
        int got0;
        int got1;
        handshake(m);
        got0 = -1;
        got1 = -1;
        for (int k = 1; k <= 400 && (got0 < 0 || got1 < 0); k++) begin
            if (got0 < 0 && rdy_w[0]) got0 = k;
            if (got1 < 0 && rdy_w[1]) got1 = k;
            if (got0 < 0 || got1 < 0) begin
                @(posedge clk); #1;
            end
        end
        chk($sformatf("len0_%06h", m), got0, exp0);
        chk($sformatf("len1_%06h", m), got1, exp1);
    endtask

    initial begin
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_i     = '0;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_tx%0d", d), tx_w[d], 1'b1);
            chk($sformatf("rst_ready%0d", d), rdy_w[d], 1'b1);
            chk($sformatf("rst_busy%0d", d), busy_w[d], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        send(24'h904564, 301, 301);
        send(24'hC3057F, 201, 201);
        send(24'h903C40, 301, 301);
        send(24'h903E40, 301, 201);
        send(24'h803C00, 301, 301);
        send(24'h903C40, 301, 301);
        send(24'hF81234, 101, 101);
        send(24'h903E40, 301, 201);
        send(24'h903C40, 301, 201);
        send(24'hF01234, 101, 101);
        send(24'h903E40, 301, 301);
        send(24'h451234, 1, 1);
        chk("invalid_tx0", tx_w[0], 1'b1);
        chk("invalid_tx1", tx_w[1], 1'b1);

        // Abort during data bit 3 of the second byte (cycles 141..150 after handshake).
        handshake(24'h903C40);
        repeat (144) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort_tx%0d", d), tx_w[d], 1'b1);
            chk($sformatf("abort_ready%0d", d), rdy_w[d], 1'b1);
            chk($sformatf("abort_busy%0d", d), busy_w[d], 1'b0);
        end
        send(24'h903C40, 301, 301);

        repeat (5) @(posedge clk);
        #1;
        chk("rx0_count", rx0.size(), 32);
        chk("rx1_count", rx1.size(), 29);
        for (int i = 0; i < 32 && i < rx0.size(); i++)
            chk($sformatf("rx0_byte%0d", i), rx0[i], EXP0[i]);
        for (int i = 0; i < 29 && i < rx1.size(); i++)
            chk($sformatf("rx1_byte%0d", i), rx1[i], EXP1[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
